count_sequencer: RTL and testbench

COUNT_SEQUENCER -- requirements
Module: count_sequencer

---
 rtl/count_seq_pkg.sv | 23 ++
 rtl/count_seq_wdog.sv | 27 ++
 rtl/count_sequencer.sv | 130 +++++++++++++
 tb/tb_count_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/count_seq_pkg.sv
// Shared types and constants for the count sequencer.
// The optional watchdog is built only when COUNT_SEQ_WDOG_EN is defined.
package count_seq_pkg;

    localparam int CNT_W      = 5;
    localparam int RUN_W      = 4;
    localparam int WDOG_LIMIT = 40;
    localparam int WDOG_W     = $clog2(WDOG_LIMIT + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DONE,
        ST_ERR
    } state_t;

    // A pass count of zero behaves like a single pass.
    function automatic logic [RUN_W-1:0] last_pass_idx(input logic [RUN_W-1:0] runs);
        return (runs == '0) ? '0 : runs - RUN_W'(1);
    endfunction

endpackage

// File: rtl/count_seq_wdog.sv
// Watchdog for the count sequencer: counts consecutive RUN cycles without a terminal match.
// Instantiated by the top only when COUNT_SEQ_WDOG_EN is defined.
module count_seq_wdog
    import count_seq_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic active,
    output logic expired
);

    logic [WDOG_W-1:0] cycle_cnt_reg;

    // The sequencer leaves RUN as soon as expired is seen, so the counter never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt_reg <= '0;
        end else if (!active) begin
            cycle_cnt_reg <= '0;
        end else begin
            cycle_cnt_reg <= cycle_cnt_reg + WDOG_W'(1);
        end
    end

    assign expired = active && (cycle_cnt_reg == WDOG_W'(WDOG_LIMIT - 1));

endmodule

// File: rtl/count_sequencer.sv
// Command-driven sequencer that loads and runs an external 5-bit rollover counter for N passes.
// Define COUNT_SEQ_WDOG_EN to build the RUN-state watchdog and the ERR exit path.
module count_sequencer
    import count_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_start,
    input  logic [CNT_W-1:0] cmd_end,
    input  logic [RUN_W-1:0] cmd_runs,
    input  logic             abort,
    output logic             cnt_load,
    output logic             cnt_enable,
    output logic [CNT_W-1:0] cnt_start_val,
    input  logic [CNT_W-1:0] cnt_count,
    output logic             busy,
    output logic             done,
    output logic [RUN_W-1:0] run_idx,
    output logic             err
);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] start_reg, start_next;
    logic [CNT_W-1:0] end_reg, end_next;
    logic [RUN_W-1:0] last_reg, last_next;
    logic [RUN_W-1:0] run_idx_reg, run_idx_next;

    logic accept;
    logic match;
    logic wdog_expired;

    // Reset forces IDLE asynchronously; ready is additionally masked while rst is held.
    assign cmd_ready     = (state_reg == ST_IDLE) && !rst;
    assign accept        = cmd_valid && cmd_ready;
    assign match         = (cnt_count == end_reg);
    assign cnt_start_val = start_reg;
    assign run_idx       = run_idx_reg;

`ifdef COUNT_SEQ_WDOG_EN
    count_seq_wdog u_wdog (
        .clk     (clk),
        .rst     (rst),
        .active  ((state_reg == ST_RUN) && !match),
        .expired (wdog_expired)
    );
    assign err = (state_reg == ST_ERR);
`else
    assign wdog_expired = 1'b0;
    assign err          = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            start_reg   <= '0;
            end_reg     <= '0;
            last_reg    <= '0;
            run_idx_reg <= '0;
        end else begin
            state_reg   <= state_next;
            start_reg   <= start_next;
            end_reg     <= end_next;
            last_reg    <= last_next;
            run_idx_reg <= run_idx_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        start_next   = start_reg;
        end_next     = end_reg;
        last_next    = last_reg;
        run_idx_next = run_idx_reg;
        cnt_load     = 1'b0;
        cnt_enable   = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                busy = 1'b0;
                // abort has no meaning in IDLE, so a simultaneous command is still taken.
                if (accept) begin
                    start_next   = cmd_start;
                    end_next     = cmd_end;
                    last_next    = last_pass_idx(cmd_runs);
                    run_idx_next = '0;
                    state_next   = ST_LOAD;
                end
            end

            ST_LOAD: begin
                cnt_load   = 1'b1;
                state_next = abort ? ST_IDLE : ST_RUN;
            end

            ST_RUN: begin
                cnt_enable = !match;
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (match) begin
                    if (run_idx_reg == last_reg) begin
                        state_next = ST_DONE;
                    end else begin
                        run_idx_next = run_idx_reg + RUN_W'(1);
                        state_next   = ST_LOAD;
                    end
                end else if (wdog_expired) begin
                    state_next = ST_ERR;
                end
            end

            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end

            ST_ERR: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_count_sequencer.sv
// Self-checking bench for count_sequencer with a behavioural model of the external counter.
// Watchdog expectations follow COUNT_SEQ_WDOG_EN.
module tb_count_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [4:0] cmd_start = '0;
    logic [4:0] cmd_end = '0;
    logic [3:0] cmd_runs = '0;
    logic       abort = 1'b0;
    logic       cnt_load;
    logic       cnt_enable;
    logic [4:0] cnt_start_val;
    logic [4:0] cnt_count;
    logic       busy;
    logic       done;
    logic [3:0] run_idx;
    logic       err;

    logic [4:0] cnt_model = '0;
    logic       stuck = 1'b0;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct packed {
        logic       load;
        logic       en;
        logic       dn;
        logic [3:0] idx;
        logic [4:0] cnt;
        logic       chk_cnt;
    } exp_t;

    count_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_start     (cmd_start),
        .cmd_end       (cmd_end),
        .cmd_runs      (cmd_runs),
        .abort         (abort),
        .cnt_load      (cnt_load),
        .cnt_enable    (cnt_enable),
        .cnt_start_val (cnt_start_val),
        .cnt_count     (cnt_count),
        .busy          (busy),
        .done          (done),
        .run_idx       (run_idx),
        .err           (err)
    );

    always #5 clk = ~clk;

    // External 5-bit rollover counter; "stuck" pins it at 4 for the watchdog scenario.
    always @(posedge clk) begin
        if (stuck)           cnt_model <= 5'd4;
        else if (cnt_load)   cnt_model <= cnt_start_val;
        else if (cnt_enable) cnt_model <= cnt_model + 5'd1;
    end
    assign cnt_count = cnt_model;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        total_cnt++; if ({cnt_load, cnt_enable, busy, done, err, cmd_ready} !== 6'b0) $display("FAIL reset_outs: got %b expected 000000", {cnt_load, cnt_enable, busy, done, err, cmd_ready}); else pass_cnt++;
        total_cnt++; if (cnt_start_val !== 5'd0) $display("FAIL reset_start_val: got %0d expected 0", cnt_start_val); else pass_cnt++;
        step();
        rst = 1'b0;
        #1;
        total_cnt++; if (cmd_ready !== 1'b1) $display("FAIL ready_after_reset: got %b expected 1", cmd_ready); else pass_cnt++;
        step();
        // Reset in the middle of a RUN pass.
        cmd_valid = 1'b1; cmd_start = 5'd0; cmd_end = 5'd20; cmd_runs = 4'd1;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        total_cnt++; if (cnt_enable !== 1'b1) $display("FAIL pre_reset_enable: got %b expected 1", cnt_enable); else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        total_cnt++; if ({cnt_load, cnt_enable, busy, done, err, cmd_ready} !== 6'b0) $display("FAIL midrun_reset_outs: got %b expected 000000", {cnt_load, cnt_enable, busy, done, err, cmd_ready}); else pass_cnt++;
        total_cnt++; if (cnt_start_val !== 5'd0 || run_idx !== 4'd0) $display("FAIL midrun_reset_regs: got start_val %0d run_idx %0d expected 0 0", cnt_start_val, run_idx); else pass_cnt++;
        step();
        rst = 1'b0;
        #1;
        total_cnt++; if (cmd_ready !== 1'b1 || busy !== 1'b0) $display("FAIL midrun_reset_release: got ready %b busy %b expected 1 0", cmd_ready, busy); else pass_cnt++;
        $display("reset: checks done");
        step();
    endtask

    task automatic test_sequences(input int n_random);
        int   tbl_s[3] = '{3, 30, 5};
        int   tbl_e[3] = '{7, 2, 5};
        int   tbl_r[3] = '{1, 1, 3};
        exp_t exp_q[$];
        exp_t ex;
        for (int n = 0; n < 3 + n_random; n++) begin
            int s, e, r, re, d, cyc, done_cyc, loads, ens;
            if (n < 3) begin
                s = tbl_s[n]; e = tbl_e[n]; r = tbl_r[n];
            end else begin
                s = int'($urandom_range(0, 31)); e = int'($urandom_range(0, 31)); r = int'($urandom_range(0, 15));
            end
            re = (r == 0) ? 1 : r;
            d  = (e - s + 32) % 32;
            exp_q.delete();
            for (int p = 0; p < re; p++) begin
                exp_q.push_back('{load: 1'b1, en: 1'b0, dn: 1'b0, idx: 4'(p), cnt: 5'd0, chk_cnt: 1'b0});
                for (int k = 0; k < d; k++)
                    exp_q.push_back('{load: 1'b0, en: 1'b1, dn: 1'b0, idx: 4'(p), cnt: 5'((s + k) % 32), chk_cnt: 1'b1});
                exp_q.push_back('{load: 1'b0, en: 1'b0, dn: 1'b0, idx: 4'(p), cnt: 5'(e), chk_cnt: 1'b1});
            end
            exp_q.push_back('{load: 1'b0, en: 1'b0, dn: 1'b1, idx: 4'(re - 1), cnt: 5'd0, chk_cnt: 1'b0});

            total_cnt++; if (cmd_ready !== 1'b1) $display("FAIL seq_ready: got %b expected 1 (cmd %0d)", cmd_ready, n); else pass_cnt++;
            cmd_valid = 1'b1; cmd_start = 5'(s); cmd_end = 5'(e); cmd_runs = 4'(r);
            step();
            cmd_valid = 1'b0;
            cyc = 1; done_cyc = -1; loads = 0; ens = 0;
            foreach (exp_q[i]) begin
                ex = exp_q[i];
                if (cnt_load) loads++;
                if (cnt_enable) ens++;
                if (done && done_cyc < 0) done_cyc = cyc;
                total_cnt++; if ({cnt_load, cnt_enable, done, busy} !== {ex.load, ex.en, ex.dn, 1'b1}) $display("FAIL seq_ctrl: got ld/en/done/busy %b expected %b (cmd %0d cycle %0d)", {cnt_load, cnt_enable, done, busy}, {ex.load, ex.en, ex.dn, 1'b1}, n, cyc); else pass_cnt++;
                total_cnt++; if (run_idx !== ex.idx) $display("FAIL seq_run_idx: got %0d expected %0d (cmd %0d cycle %0d)", run_idx, ex.idx, n, cyc); else pass_cnt++;
                if (ex.load) begin
                    total_cnt++; if (cnt_start_val !== 5'(s)) $display("FAIL seq_start_val: got %0d expected %0d (cmd %0d)", cnt_start_val, s, n); else pass_cnt++;
                end
                if (ex.chk_cnt) begin
                    total_cnt++; if (cnt_count !== ex.cnt) $display("FAIL seq_count: got %0d expected %0d (cmd %0d cycle %0d)", cnt_count, ex.cnt, n, cyc); else pass_cnt++;
                end
                // Commands offered while busy must be ignored.
                cmd_valid = 1'($urandom); cmd_start = 5'($urandom); cmd_end = 5'($urandom); cmd_runs = 4'($urandom);
                step();
                cyc++;
            end
            cmd_valid = 1'b0;
            total_cnt++; if ({busy, done, cmd_ready} !== 3'b001) $display("FAIL seq_idle: got busy/done/ready %b expected 001 (cmd %0d)", {busy, done, cmd_ready}, n); else pass_cnt++;
            total_cnt++; if (loads !== re) $display("FAIL seq_loads: got %0d expected %0d (cmd %0d)", loads, re, n); else pass_cnt++;
            total_cnt++; if (ens !== re * d) $display("FAIL seq_enables: got %0d expected %0d (cmd %0d)", ens, re * d, n); else pass_cnt++;
            total_cnt++; if (done_cyc !== re * (d + 2) + 1) $display("FAIL seq_done_cycle: got %0d expected %0d (cmd %0d)", done_cyc, re * (d + 2) + 1, n); else pass_cnt++;
            $display("seq %0d: start=%0d end=%0d runs=%0d enables=%0d done_cycle=%0d", n, s, e, r, ens, done_cyc);
        end
    endtask

    task automatic test_abort();
        int dones;
        // Abort in the second RUN cycle.
        cmd_valid = 1'b1; cmd_start = 5'd0; cmd_end = 5'd10; cmd_runs = 4'd1;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        total_cnt++; if (cnt_enable !== 1'b1) $display("FAIL abort_pre_enable: got %b expected 1", cnt_enable); else pass_cnt++;
        abort = 1'b1;
        step();
        abort = 1'b0;
        total_cnt++; if ({busy, cnt_enable, cnt_load, done, cmd_ready} !== 5'b00001) $display("FAIL abort_run_idle: got %b expected 00001", {busy, cnt_enable, cnt_load, done, cmd_ready}); else pass_cnt++;
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            if (done || busy) dones++;
            step();
        end
        total_cnt++; if (dones !== 0) $display("FAIL abort_no_done: got %0d active cycles expected 0", dones); else pass_cnt++;
        // Abort with accept in IDLE still accepts.
        abort = 1'b1; cmd_valid = 1'b1; cmd_start = 5'd2; cmd_end = 5'd6; cmd_runs = 4'd1;
        step();
        abort = 1'b0; cmd_valid = 1'b0;
        total_cnt++; if ({cnt_load, busy} !== 2'b11 || cnt_start_val !== 5'd2) $display("FAIL abort_idle_accept: got ld/busy %b start_val %0d expected 11 2", {cnt_load, busy}, cnt_start_val); else pass_cnt++;
        // Abort in LOAD.
        abort = 1'b1;
        step();
        abort = 1'b0;
        total_cnt++; if (busy !== 1'b0) $display("FAIL abort_load: got busy %b expected 0", busy); else pass_cnt++;
        // Abort beats a terminal match.
        cmd_valid = 1'b1; cmd_start = 5'd8; cmd_end = 5'd8; cmd_runs = 4'd2;
        step();
        cmd_valid = 1'b0;
        step();
        total_cnt++; if ({cnt_enable, busy} !== 2'b01) $display("FAIL abort_match_pre: got en/busy %b expected 01", {cnt_enable, busy}); else pass_cnt++;
        abort = 1'b1;
        step();
        abort = 1'b0;
        total_cnt++; if ({busy, done} !== 2'b00 || run_idx !== 4'd0) $display("FAIL abort_match: got busy/done %b run_idx %0d expected 00 0", {busy, done}, run_idx); else pass_cnt++;
        $display("abort: checks done");
        step();
    endtask

    task automatic test_watchdog();
        int err_cyc, errs, cyc;
        logic idle_seen;
        stuck = 1'b1;
        step();
        cmd_valid = 1'b1; cmd_start = 5'd0; cmd_end = 5'd9; cmd_runs = 4'd1;
        step();
        cmd_valid = 1'b0;
        err_cyc = -1; errs = 0; idle_seen = 1'b0;
`ifdef COUNT_SEQ_WDOG_EN
        for (cyc = 1; cyc <= 80; cyc++) begin
            if (err) begin
                errs++;
                if (err_cyc < 0) err_cyc = cyc;
                total_cnt++; if (cnt_enable !== 1'b0) $display("FAIL wdog_err_enable: got %b expected 0", cnt_enable); else pass_cnt++;
            end
            if (!busy) begin
                idle_seen = 1'b1;
                break;
            end
            step();
        end
        total_cnt++; if (err_cyc !== 42) $display("FAIL wdog_err_cycle: got %0d expected 42", err_cyc); else pass_cnt++;
        total_cnt++; if (errs !== 1) $display("FAIL wdog_err_pulses: got %0d expected 1", errs); else pass_cnt++;
        total_cnt++; if (idle_seen !== 1'b1 || cyc !== 43) $display("FAIL wdog_idle: got idle %b at cycle %0d expected 1 at 43", idle_seen, cyc); else pass_cnt++;
`else
        for (cyc = 1; cyc <= 60; cyc++) begin
            if (err) errs++;
            step();
        end
        total_cnt++; if ({busy, cnt_enable} !== 2'b11) $display("FAIL wdog_off_busy: got busy/en %b expected 11", {busy, cnt_enable}); else pass_cnt++;
        total_cnt++; if (errs !== 0) $display("FAIL wdog_off_err: got %0d pulses expected 0", errs); else pass_cnt++;
        abort = 1'b1;
        step();
        abort = 1'b0;
        idle_seen = !busy;
        total_cnt++; if (idle_seen !== 1'b1) $display("FAIL wdog_off_abort: got busy %b expected 0", busy); else pass_cnt++;
`endif
        stuck = 1'b0;
        $display("watchdog: err_cycle=%0d pulses=%0d", err_cyc, errs);
        step();
    endtask

    initial begin
        test_reset();
        test_sequences(16);
        test_abort();
        test_watchdog();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
